// File: rtl/exec_wb_stage_pkg.sv
// Shared encodings for the execute/write-back stage: result sources, branch codes,
// SZCV flag bit positions and the buffered write-back entry layout.
package exec_wb_stage_pkg;

  localparam int DATA_W = 16;
  localparam int RD_W   = 3;

  localparam int FLG_S = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_SH  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_IMM = 2'd3
  } sel_e;

  typedef enum logic [2:0] {
    BR_BE  = 3'd0,
    BR_BLT = 3'd1,
    BR_BLE = 3'd2,
    BR_BNE = 3'd3
  } br_cond_e;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              wen;
  } wb_entry_t;

  // Codes 4-7 are reserved and never taken.
  function automatic logic br_eval(input logic [2:0] cond, input logic [3:0] szcv);
    logic w_lt;
    w_lt = szcv[FLG_S] ^ szcv[FLG_V];
    case (cond)
      BR_BE:   br_eval = szcv[FLG_Z];
      BR_BLT:  br_eval = w_lt;
      BR_BLE:  br_eval = szcv[FLG_Z] | w_lt;
      BR_BNE:  br_eval = ~szcv[FLG_Z];
      default: br_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry write-back skid buffer. Ready is registered from the next occupancy so it
// never depends combinationally on the downstream ready.
module wb_skid_buf
  import exec_wb_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  output logic      o_ready,
  input  logic      i_pop,
  output logic      o_valid,
  output wb_entry_t o_entry
);

  wb_entry_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_ready;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push      = i_push & r_ready;
  assign w_pop       = i_pop & (r_count != 2'd0);
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Outputs are zeroed while empty so stale entries never leak downstream.
  assign o_ready = r_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_entry = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: selects the result, buffers it for write-back, keeps the
// committed SZCV flags, resolves conditional branches and counts retired entries.
module exec_wb_stage
  import exec_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] sh_res,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        alu_szcv,
  input  logic [3:0]        sh_szcv,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_flag_en,
  input  logic              br_req,
  input  logic [2:0]        br_cond,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_wen,
  output logic [3:0]        flags_q,
  output logic              br_taken,
  output logic [15:0]       retired_cnt
);

  logic              w_accept;
  logic              w_drain;
  logic [DATA_W-1:0] w_sel_data;
  wb_entry_t         w_in_entry;
  wb_entry_t         w_out_entry;

  logic [3:0]        r_flags;
  logic              r_br_taken;
  logic [15:0]       r_retired;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = wb_valid & wb_ready;

  always_comb begin
    w_sel_data = alu_res;
    case (in_sel)
      SEL_ALU: w_sel_data = alu_res;
      SEL_SH:  w_sel_data = sh_res;
      SEL_MEM: w_sel_data = mem_data;
      SEL_IMM: w_sel_data = imm;
      default: w_sel_data = alu_res;
    endcase
  end

  assign w_in_entry = '{rd: in_rd, data: w_sel_data, wen: in_wen};

  wb_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_entry (w_in_entry),
    .o_ready (in_ready),
    .i_pop   (wb_ready),
    .o_valid (wb_valid),
    .o_entry (w_out_entry)
  );

  assign wb_rd   = w_out_entry.rd;
  assign wb_data = w_out_entry.data;
  assign wb_wen  = w_out_entry.wen;

  // Branches see the flags committed before this edge, not the ones loaded by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags    <= 4'b0000;
      r_br_taken <= 1'b0;
      r_retired  <= 16'h0000;
    end else begin
      if (w_accept && in_flag_en) begin
        if (in_sel == SEL_ALU)     r_flags <= alu_szcv;
        else if (in_sel == SEL_SH) r_flags <= sh_szcv;
      end
      r_br_taken <= w_accept & br_req & br_eval(br_cond, r_flags);
      if (w_drain) r_retired <= r_retired + 16'd1;
    end
  end

  assign flags_q     = r_flags;
  assign br_taken    = r_br_taken;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed bench for exec_wb_stage with hand-computed expectations.
module tb_exec_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [15:0] alu_res, sh_res, mem_data, imm;
  logic [3:0]  alu_szcv, sh_szcv;
  logic [2:0]  in_rd;
  logic        in_wen, in_flag_en;
  logic        br_req;
  logic [2:0]  br_cond;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_wen;
  logic [3:0]  flags_q;
  logic        br_taken;
  logic [15:0] retired_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  exec_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .alu_res(alu_res), .sh_res(sh_res), .mem_data(mem_data),
    .imm(imm), .alu_szcv(alu_szcv), .sh_szcv(sh_szcv), .in_rd(in_rd),
    .in_wen(in_wen), .in_flag_en(in_flag_en), .br_req(br_req), .br_cond(br_cond),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_wen(wb_wen), .flags_q(flags_q), .br_taken(br_taken), .retired_cnt(retired_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one upstream transaction
  task automatic drive_op(input logic [1:0] sel, input logic [15:0] val, input logic [2:0] rd,
                          input logic wen, input logic fen, input logic [3:0] szcv,
                          input logic br, input logic [2:0] cond);
    in_valid   = 1'b1;
    in_sel     = sel;
    alu_res    = val;
    sh_res     = val;
    mem_data   = val;
    imm        = val;
    alu_szcv   = szcv;
    sh_szcv    = szcv;
    in_rd      = rd;
    in_wen     = wen;
    in_flag_en = fen;
    br_req     = br;
    br_cond    = cond;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_flag_en = 1'b0;
    br_req     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_ready = 1'b0;
    drive_op(2'd0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
    idle();
    #12;
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
    check("rst_wb_data",  wb_data, 16'h0000);
    check("rst_flags",    {12'd0, flags_q}, 16'h0000);
    check("rst_br",       {15'd0, br_taken}, 16'd0);
    check("rst_retired",  retired_cnt, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {15'd0, in_ready}, 16'd1);

    // single shifter result
    wb_ready = 1'b1;
    drive_op(2'd1, 16'h00F0, 3'd3, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd0);
    step();
    idle();
    check("sh_valid", {15'd0, wb_valid}, 16'd1);
    check("sh_data",  wb_data, 16'h00F0);
    check("sh_rd",    {13'd0, wb_rd}, 16'd3);
    check("sh_flags", {12'd0, flags_q}, 16'h0000);
    step();
    check("sh_drained", {15'd0, wb_valid}, 16'd0);
    check("sh_retired", retired_cnt, 16'd1);

    // backpressure: two accepted, third held, then in-order drain
    wb_ready = 1'b0;
    drive_op(2'd0, 16'h1111, 3'd1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0);
    exp_q.push_back(16'h1111);
    step();
    drive_op(2'd0, 16'h2222, 3'd2, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
    exp_q.push_back(16'h2222);
    step();
    check("bp_full_ready", {15'd0, in_ready}, 16'd0);
    drive_op(2'd3, 16'h3333, 3'd5, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0);
    exp_q.push_back(16'h3333);
    step();
    check("bp_held_ready", {15'd0, in_ready}, 16'd0);
    check("bp_head_data", wb_data, exp_q[0]);
    check("bp_head_wen",  {15'd0, wb_wen}, 16'd1);
    check("bp_head_rd",   {13'd0, wb_rd}, 16'd1);
    wb_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    check("bp_drain1_data", wb_data, exp_q[0]);
    check("bp_drain1_wen",  {15'd0, wb_wen}, 16'd0);
    check("bp_drain1_ready", {15'd0, in_ready}, 16'd1);
    step();
    void'(exp_q.pop_front());
    idle();
    check("bp_drain2_data", wb_data, exp_q[0]);
    check("bp_drain2_rd",   {13'd0, wb_rd}, 16'd5);
    step();
    void'(exp_q.pop_front());
    check("bp_empty", {15'd0, wb_valid}, 16'd0);
    check("bp_retired", retired_cnt, 16'd4);

    // branches against flags 0100 (Z set)
    drive_op(2'd0, 16'h0000, 3'd1, 1'b1, 1'b1, 4'b0100, 1'b0, 3'd0);
    step();
    check("br_flags", {12'd0, flags_q}, 16'h0004);
    drive_op(2'd0, 16'h0001, 3'd1, 1'b0, 1'b0, 4'h0, 1'b1, 3'd0);
    step();
    check("br_be", {15'd0, br_taken}, 16'd1);
    drive_op(2'd0, 16'h0002, 3'd1, 1'b0, 1'b0, 4'h0, 1'b1, 3'd3);
    step();
    check("br_bne", {15'd0, br_taken}, 16'd0);
    drive_op(2'd0, 16'h0003, 3'd1, 1'b0, 1'b0, 4'h0, 1'b1, 3'd2);
    step();
    check("br_ble", {15'd0, br_taken}, 16'd1);
    drive_op(2'd0, 16'h0004, 3'd1, 1'b0, 1'b0, 4'h0, 1'b1, 3'd1);
    step();
    check("br_blt", {15'd0, br_taken}, 16'd0);
    drive_op(2'd0, 16'h0005, 3'd1, 1'b0, 1'b0, 4'h0, 1'b1, 3'd5);
    step();
    check("br_rsvd", {15'd0, br_taken}, 16'd0);
    idle();
    br_req = 1'b1;
    br_cond = 3'd0;
    step();
    check("br_no_accept", {15'd0, br_taken}, 16'd0);

    // same-cycle flag update and branch
    drive_op(2'd0, 16'h0006, 3'd2, 1'b1, 1'b1, 4'b1000, 1'b0, 3'd0);
    step();
    check("sc_flags_pre", {12'd0, flags_q}, 16'h0008);
    drive_op(2'd0, 16'h0007, 3'd2, 1'b1, 1'b1, 4'b0000, 1'b1, 3'd1);
    step();
    check("sc_br", {15'd0, br_taken}, 16'd1);
    check("sc_flags_post", {12'd0, flags_q}, 16'h0000);

    // load/immediate selects leave flags alone; shifter flags load
    drive_op(2'd2, 16'h1234, 3'd4, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd0);
    step();
    check("mem_data", wb_data, 16'h1234);
    check("mem_flags", {12'd0, flags_q}, 16'h0000);
    drive_op(2'd3, 16'hBEEF, 3'd6, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd0);
    step();
    check("imm_data", wb_data, 16'hBEEF);
    check("imm_flags", {12'd0, flags_q}, 16'h0000);
    drive_op(2'd1, 16'h0F0F, 3'd7, 1'b1, 1'b1, 4'b0011, 1'b0, 3'd0);
    step();
    idle();
    check("sh_flag_load", {12'd0, flags_q}, 16'h0003);
    check("sh_data2", wb_data, 16'h0F0F);
    step();

    // asynchronous reset with two entries buffered
    wb_ready = 1'b0;
    drive_op(2'd0, 16'hAAAA, 3'd1, 1'b1, 1'b1, 4'b0110, 1'b0, 3'd0);
    step();
    drive_op(2'd0, 16'hBBBB, 3'd2, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0);
    step();
    idle();
    check("ar_full", {15'd0, in_ready}, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_wb_valid", {15'd0, wb_valid}, 16'd0);
    check("ar_flags",    {12'd0, flags_q}, 16'h0000);
    check("ar_retired",  retired_cnt, 16'h0000);
    check("ar_wb_data",  wb_data, 16'h0000);
    step();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    step();
    check("ar_discarded", {15'd0, wb_valid}, 16'd0);
    check("ar_ready", {15'd0, in_ready}, 16'd1);

    // retired counter wrap: 65535 streamed drains, then one more
    drive_op(2'd3, 16'h0055, 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
    for (int i = 0; i < 65535; i++) step();
    idle();
    step();
    check("wrap_ffff", retired_cnt, 16'hFFFF);
    drive_op(2'd3, 16'h0066, 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
    step();
    idle();
    step();
    check("wrap_zero", retired_cnt, 16'h0000);
    check("wrap_empty", {15'd0, wb_valid}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_wb_stage.md
EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  in  1  upstream execute-stage result valid.
REQ-004 SHALL have port in_ready  out  1  stage can accept a transaction.
REQ-005 SHALL have port in_sel  in  2  source: 0 ALU, 1 shifter, 2 load data, 3 immediate.
REQ-006 SHALL have ports alu_res / sh_res / mem_data / imm  in  16 each  candidate results.
REQ-007 SHALL have ports alu_szcv / sh_szcv  in  4 each  flags {S,Z,C,V}.
REQ-008 SHALL have ports in_rd  in  3 (destination register), in_wen  in  1, in_flag_en  in  1.
REQ-009 SHALL have ports br_req  in  1 and br_cond  in  3  conditional-branch request and code.
REQ-010 SHALL have ports wb_valid  out  1, wb_ready  in  1, wb_rd  out  3, wb_data  out  16, wb_wen  out  1.
REQ-011 SHALL have ports flags_q  out  4  committed SZCV; br_taken  out  1; retired_cnt  out  16.

Function
REQ-012 Accept SHALL occur on in_valid & in_ready; drain SHALL occur on wb_valid & wb_ready.
REQ-013 Result SHALL be selected by in_sel at accept and stored with in_rd, in_wen in a 2-entry FIFO (skid buffer).
REQ-014 in_ready SHALL be 1 whenever the FIFO holds fewer than 2 entries, registered (not combinationally derived from wb_ready).
REQ-015 wb_valid SHALL be 1 when the FIFO is non-empty; wb_* SHALL present the oldest entry; latency from accept to wb_valid SHALL be 1 cycle when empty.
REQ-016 Simultaneous accept and drain SHALL keep occupancy constant; when full, accept SHALL be blocked, and drain plus accept in one cycle SHALL not occur.
REQ-017 FIFO pointers SHALL wrap modulo 2; ordering SHALL be strictly FIFO.
REQ-018 On accept with in_flag_en=1, flags_q SHALL load alu_szcv (in_sel=0) or sh_szcv (in_sel=1); for in_sel 2/3 flags_q SHALL be unchanged.
REQ-019 Branch conditions on accept with br_req=1: 0 BE = Z; 1 BLT = S^V; 2 BLE = Z|(S^V); 3 BNE = !Z; 4-7 never taken.
REQ-020 Branch evaluation SHALL use flags_q before any same-cycle flag update.
REQ-021 br_taken SHALL be a one-cycle pulse in the cycle after the accepting edge; 0 otherwise.
REQ-022 retired_cnt SHALL increment by 1 per drain, wrapping 0xFFFF -> 0x0000.
REQ-023 Entries with in_wen=0 SHALL still pass through the FIFO and count as retired.

Reset
REQ-024 rst_n low SHALL immediately clear FIFO (empty), flags_q=0000, br_taken=0, retired_cnt=0, wb_valid=0, wb_wen=0, wb_rd=0, wb_data=0.
REQ-025 in_ready SHALL be 0 during reset and 1 on the first clock after rst_n deasserts.
REQ-026 Reset mid-operation SHALL discard buffered entries without draining them.

Structure
REQ-027 A shared package SHALL hold in_sel encodings, br_cond encodings, SZCV bit indices (S=3, Z=2, C=1, V=0), and data width 16.
REQ-028 The FIFO SHALL be a sub-module named wb_skid_buf; flag/branch logic stays in exec_wb_stage.

Verification
REQ-029 Single shifter result: in_sel=1, sh_res=0x00F0, in_rd=3, in_flag_en=1, sh_szcv=0000, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x00F0, wb_rd=3; flags_q=0000.
REQ-030 Backpressure: wb_ready=0, three back-to-back accepts offered -> two accepted, in_ready=0, third held; wb_ready=1 -> data drained in order.
REQ-031 Branch: accept ALU result with alu_szcv=0100 and flag_en=1, then BE (cond 0) -> br_taken=1 for one cycle; BNE in the same sequence -> br_taken=0.
REQ-032 Same-cycle flag and branch: flags_q=1000, accept with flag_en=1, alu_szcv=0000, br_req=1, cond=1 -> br_taken=1, then flags_q=0000.
REQ-033 Counter wrap: preload 0xFFFF drains, drain once more -> retired_cnt=0x0000.
REQ-034 Asynchronous reset asserted with 2 entries buffered -> wb_valid=0 and flags_q=0000 before the next clock edge.
